// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: MEM/WB control bit positions, register-file geometry and
// register-index helpers used by the writeback stage and earlier pipeline registers.
package pipeline_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DEPTH = 32;

  localparam int unsigned WB_REGWRITE_BIT = 1;
  localparam int unsigned WB_MEMTOREG_BIT = 0;

  typedef logic [4:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  function automatic logic is_zero(input reg_idx_t idx);
    return idx == REG_ZERO;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Raw register storage: one posedge write port and three unfiltered combinational read ports.
// Zero-register and bypass handling live in the caller.
module regfile_2r1w
  import pipeline_pkg::*;
#(
  parameter int unsigned Depth = DEFAULT_DEPTH,
  parameter int unsigned Width = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  reg_idx_t         waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  reg_idx_t         raddr_a_i,
  input  reg_idx_t         raddr_b_i,
  input  reg_idx_t         raddr_dbg_i,
  output logic [Width-1:0] rdata_a_o,
  output logic [Width-1:0] rdata_b_o,
  output logic [Width-1:0] rdata_dbg_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o   = mem_q[raddr_a_i];
  assign rdata_b_o   = mem_q[raddr_b_i];
  assign rdata_dbg_o = mem_q[raddr_dbg_i];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the MEM/WB result, commits it to the register file on posedge,
// and serves the ID read ports with same-cycle write-to-read bypass.
module wb_regfile
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       WB_in,
  input  reg_idx_t         Rw_in,
  input  logic [WIDTH-1:0] ALUout_in,
  input  logic [WIDTH-1:0] DataMem_in,
  input  reg_idx_t         Ra,
  input  reg_idx_t         Rb,
  output logic [WIDTH-1:0] Da,
  output logic [WIDTH-1:0] Db,
  input  reg_idx_t         dbg_idx,
  output logic [WIDTH-1:0] dbg_data,
  output logic [WIDTH-1:0] wb_data,
  output logic [31:0]      wb_count
);

  logic             we;
  logic [WIDTH-1:0] rf_a;
  logic [WIDTH-1:0] rf_b;
  logic [WIDTH-1:0] rf_dbg;
  logic [31:0]      wb_count_q;
  logic [31:0]      wb_count_d;

  assign wb_data = WB_in[WB_MEMTOREG_BIT] ? DataMem_in : ALUout_in;
  assign we      = WB_in[WB_REGWRITE_BIT] && !is_zero(Rw_in);

  regfile_2r1w #(
    .Depth (DEPTH),
    .Width (WIDTH)
  ) u_regfile (
    .clk_i       (clk),
    .rst_ni      (reset),
    .we_i        (we),
    .waddr_i     (Rw_in),
    .wdata_i     (wb_data),
    .raddr_a_i   (Ra),
    .raddr_b_i   (Rb),
    .raddr_dbg_i (dbg_idx),
    .rdata_a_o   (rf_a),
    .rdata_b_o   (rf_b),
    .rdata_dbg_o (rf_dbg)
  );

  // Bypass is independent of reset: a live write is visible even while storage is cleared.
  always_comb begin
    Da = rf_a;
    if (is_zero(Ra)) begin
      Da = '0;
    end else if (we && (Ra == Rw_in)) begin
      Da = wb_data;
    end
  end

  always_comb begin
    Db = rf_b;
    if (is_zero(Rb)) begin
      Db = '0;
    end else if (we && (Rb == Rw_in)) begin
      Db = wb_data;
    end
  end

  assign dbg_data = is_zero(dbg_idx) ? '0 : rf_dbg;

  always_comb begin
    wb_count_d = wb_count_q;
    if (we) begin
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_count_q <= '0;
    end else begin
      wb_count_q <= wb_count_d;
    end
  end

  assign wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: a reference model predicts committed state; expectations are queued
// when a write is driven and popped after the commit edge to compare against dbg_data/wb_count.
module tb_wb_regfile;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  WB_in;
  logic [4:0]  Rw_in;
  logic [31:0] ALUout_in;
  logic [31:0] DataMem_in;
  logic [4:0]  Ra;
  logic [4:0]  Rb;
  logic [31:0] Da;
  logic [31:0] Db;
  logic [4:0]  dbg_idx;
  logic [31:0] dbg_data;
  logic [31:0] wb_data;
  logic [31:0] wb_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [4:0]  idx;
    logic [31:0] val;
    logic [31:0] cnt;
  } sb_item_t;

  sb_item_t    sb_q[$];
  logic [31:0] model_rf [32];
  logic [31:0] model_cnt;

  wb_regfile dut (
    .clk        (clk),
    .reset      (reset),
    .WB_in      (WB_in),
    .Rw_in      (Rw_in),
    .ALUout_in  (ALUout_in),
    .DataMem_in (DataMem_in),
    .Ra         (Ra),
    .Rb         (Rb),
    .Da         (Da),
    .Db         (Db),
    .dbg_idx    (dbg_idx),
    .dbg_data   (dbg_data),
    .wb_data    (wb_data),
    .wb_count   (wb_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_wbd();
    return WB_in[1'b0] ? DataMem_in : ALUout_in;
  endfunction

  function automatic logic model_we();
    return WB_in[1] && (Rw_in != 5'd0);
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (model_we() && idx == Rw_in) return model_wbd();
    return model_rf[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    model_cnt = 32'd0;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [4:0] rw, input logic [31:0] alu,
                       input logic [31:0] mem);
    @(negedge clk);
    WB_in      = wb;
    Rw_in      = rw;
    ALUout_in  = alu;
    DataMem_in = mem;
    #1;
  endtask

  // Predict the posedge outcome, queue it, then check it after the edge.
  task automatic commit(input string tag);
    sb_item_t it;
    if (reset && model_we()) begin
      model_rf[Rw_in] = model_wbd();
      model_cnt       = model_cnt + 32'd1;
    end
    it.tag = tag;
    it.idx = Rw_in;
    it.val = model_rf[Rw_in];
    it.cnt = model_cnt;
    sb_q.push_back(it);
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      it      = sb_q.pop_front();
      dbg_idx = it.idx;
      #1;
      check_eq({it.tag, "_dbg"}, dbg_data, it.val);
      check_eq({it.tag, "_cnt"}, wb_count, it.cnt);
    end
  endtask

  initial begin
    reset      = 1'b0;
    WB_in      = 2'b00;
    Rw_in      = 5'd0;
    ALUout_in  = 32'd0;
    DataMem_in = 32'd0;
    Ra         = 5'd0;
    Rb         = 5'd0;
    dbg_idx    = 5'd5;
    model_clear();
    #2;
    check_eq("rst_cnt0", wb_count, 32'd0);
    check_eq("rst_dbg5", dbg_data, 32'd0);

    // Write attempted under reset must not commit.
    drive(2'b10, 5'd5, 32'h1234, 32'd0);
    commit("rst_hold");
    @(negedge clk);
    reset = 1'b1;
    #1;
    commit("rst_rel");

    // Writeback mux.
    drive(2'b11, 5'd7, 32'hAAAA_0000, 32'hDEAD_BEEF);
    check_eq("mux_load", wb_data, 32'hDEAD_BEEF);
    commit("mux_r7_load");
    drive(2'b10, 5'd7, 32'hAAAA_0000, 32'hDEAD_BEEF);
    check_eq("mux_alu", wb_data, 32'hAAAA_0000);
    commit("mux_r7_alu");

    // Register zero.
    Ra = 5'd0;
    drive(2'b10, 5'd0, 32'hFFFF_FFFF, 32'd0);
    check_eq("zero_da", Da, 32'd0);
    commit("zero_wr");

    // Bypass.
    drive(2'b10, 5'd3, 32'h11, 32'd0);
    commit("byp_pre");
    Ra = 5'd3;
    Rb = 5'd3;
    dbg_idx = 5'd3;
    drive(2'b00, 5'd3, 32'h22, 32'd0);
    check_eq("byp_off_da", Da, 32'h11);
    drive(2'b10, 5'd3, 32'h22, 32'd0);
    check_eq("byp_da", Da, 32'h22);
    check_eq("byp_db", Db, 32'h22);
    check_eq("byp_dbg", dbg_data, 32'h11);
    commit("byp_post");

    // Random traffic through both read ports.
    for (int i = 0; i < 24; i++) begin
      Ra = 5'($urandom_range(31));
      Rb = (i % 4 == 0) ? Ra : 5'($urandom_range(31));
      drive(2'($urandom_range(3)), 5'($urandom_range(31)), $urandom, $urandom);
      if (i % 3 == 0) Ra = Rw_in;
      #1;
      check_eq("rnd_wbd", wb_data, model_wbd());
      check_eq("rnd_da", Da, model_rd(Ra));
      check_eq("rnd_db", Db, model_rd(Rb));
      commit("rnd");
    end

    // Counter wrap via preload.
    @(negedge clk);
    WB_in = 2'b00;
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    #1;
    check_eq("wrap_pre", wb_count, 32'hFFFF_FFFF);
    model_cnt = 32'hFFFF_FFFF;
    drive(2'b10, 5'd9, 32'h99, 32'd0);
    commit("wrap");

    // Asynchronous reset between edges.
    drive(2'b10, 5'd12, 32'hC0FF_EE00, 32'd0);
    commit("pre_rst");
    drive(2'b00, 5'd0, 32'd0, 32'd0);
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check_eq("arst_cnt", wb_count, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_idx = 5'(i);
      #0.1;
      check_eq("arst_dbg", dbg_data, 32'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    drive(2'b11, 5'd20, 32'd0, 32'h5555_AAAA);
    commit("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-side consumer of the MEM/WB pipeline register: it decodes the MEM/WB control bits, selects the write-back data, and commits it into the 32×32 general-purpose register file. It also serves the two combinational read ports used by the ID stage, with same-cycle write-to-read bypass. A retired-write counter and a debug read port are provided for the bench.

## Interface
- DEPTH, 32, number of architectural registers (indices 0..DEPTH-1)
- WIDTH, 32, register and data width in bits
- clk  in  1  clock; register file commits on posedge
- reset  in  1  asynchronous, active-low reset
- WB_in  in  2  MEM/WB control: bit1 = RegWrite, bit0 = MemtoReg
- Rw_in  in  5  destination register index
- ALUout_in  in  32  ALU result from MEM/WB
- DataMem_in  in  32  load data from MEM/WB
- Ra  in  5  ID read port A index
- Rb  in  5  ID read port B index
- Da  out  32  read data A (combinational)
- Db  out  32  read data B (combinational)
- dbg_idx  in  5  debug read index
- dbg_data  out  32  debug read data (no bypass, array contents only)
- wb_data  out  32  selected write-back value (combinational)
- wb_count  out  32  count of committed register writes

## Operation
- wb_data = WB_in[0] ? DataMem_in : ALUout_in, regardless of RegWrite.
- Write enable we = WB_in[1] && (Rw_in != 0).
- On posedge clk with we=1: reg[Rw_in] <= wb_data.
- Register 0 is hardwired to zero. Writes to index 0 are dropped and do not count. Reads of index 0 return 0, including through bypass.
- Read port X (A or B):
  - Rx == 0 → 0.
  - we && Rx == Rw_in → wb_data (bypass).
  - Otherwise → reg[Rx].
- Both ports may bypass in the same cycle. Ra == Rb returns identical data on Da and Db.
- wb_count increments by 1 on every posedge with we=1. It is 32-bit unsigned and wraps 0xFFFFFFFF → 0 with no flag.
- dbg_data = reg[dbg_idx], with dbg_idx = 0 → 0. It never bypasses, so it shows committed state only.
- reset low (asynchronous): all registers go to 0 and wb_count goes to 0 immediately. Outputs follow combinationally: Da, Db and dbg_data read 0 unless a bypass hit is active. While reset is low, no write commits and the counter holds 0, even at a posedge.

## Timing
- The MEM/WB register updates on negedge clk. This block commits on the following posedge, half a cycle later.
- Read ports have zero latency.
- Bypass makes a value being written visible in the same cycle. An ID read of a register written by the instruction in WB therefore needs no extra stall.
- A committed value is visible through dbg_data from the posedge of commit onward.
- Reset release takes effect at the next posedge. The first write commits at that edge if we=1.
- Reset asserted mid-cycle discards any pending write; there is no partial commit.

## Structure
- Shared package pipeline_pkg:
  - WB_REGWRITE_BIT = 1, WB_MEMTOREG_BIT = 0
  - REG_ZERO = 5'd0
  - WIDTH and DEPTH defaults
- The EX/MEM and MEM/WB control encodings also import pipeline_pkg, so the bit meanings are defined in one place.
- One sub-module, regfile_2r1w:
  - Contents: array, async reset, one posedge write port, three raw read ports (A, B, debug).
  - The top level holds the writeback mux, the zero and bypass logic, and wb_count.

## Test plan
- **Reset:** hold reset low, apply a posedge with WB_in=2'b10, Rw_in=5, ALUout_in=0x1234. Required: wb_count=0 and dbg_idx=5 reads 0. Release reset, apply a posedge. Required: reg5=0x1234, wb_count=1.
- **Mux:** WB_in=2'b11, Rw_in=7, ALUout_in=0xAAAA0000, DataMem_in=0xDEADBEEF. Required: wb_data=0xDEADBEEF and reg7=0xDEADBEEF after posedge. Repeat with WB_in=2'b10. Required: reg7=0xAAAA0000.
- **$0:** WB_in=2'b10, Rw_in=0, ALUout_in=0xFFFFFFFF, Ra=0. Required: Da=0, dbg(0)=0, wb_count unchanged.
- **Bypass:** reg3=0x11. Set WB_in=2'b10, Rw_in=3, ALUout_in=0x22, Ra=Rb=3. Required before posedge: Da=Db=0x22 and dbg(3)=0x11. Required after posedge: dbg(3)=0x22. With WB_in=2'b00 and the same inputs, required: Da=0x11.
- **Counter wrap:** force 2^32-1 writes, or preload via hierarchical force, so wb_count=0xFFFFFFFF. One more write. Required: wb_count=0.
- **Async reset mid-cycle:** after several writes, pull reset low between edges. Required: dbg reads 0 for all indices and wb_count=0 without waiting for a clock edge.
